alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Initiator side of the 3-bit ALU operand/opcode interface. It accepts ALU commands (A, B, sel) over a valid/ready stream and buffers them in a small FIFO. It drives each command onto the ALU's A/B/sel inputs, waits a programmable settle time, and captures F/V/Z. Each captured result is returned on a valid/ready response stream, strictly in command order.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
SETTLE, 1, cycles the ALU inputs are held before F/V/Z is sampled (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready at clk edge
cmd_a  in  3  operand A
cmd_b  in  3  operand B
cmd_sel  in  4  opcode
alu_a  out  3  registered A to ALU
alu_b  out  3  registered B to ALU
alu_sel  out  4  registered opcode to ALU
alu_f  in  5  ALU result
alu_v  in  1  ALU overflow flag
alu_z  in  1  ALU zero flag
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when valid&ready at clk edge
rsp_f  out  5  captured F
rsp_v  out  1  captured V
rsp_z  out  1  captured Z
rsp_sel  out  4  opcode that produced this response
rsp_illegal  out  1  opcode > 4'b1010 (undefined)
busy  out  1  state != IDLE or FIFO non-empty
cmd_count  out  $clog2(DEPTH+1)  FIFO occupancy (excludes in-flight command)

Behaviour:
- Reset (async, rst=1): state IDLE, FIFO empty, all alu_* / rsp_* outputs 0, rsp_valid=0, busy=0, cmd_count=0, cmd_ready=0. Any in-flight command and pending response are discarded.
- cmd_ready = !full && !rst. A push occurs on an edge with cmd_valid&cmd_ready.
- FSM states:
  - IDLE: if FIFO non-empty at an edge, pop the head into alu_a/alu_b/alu_sel, load wait counter = SETTLE, go to WAIT.
  - WAIT: decrement the counter each edge. On the edge where the counter reaches 0, capture alu_f/v/z, alu_sel, and illegal = (alu_sel > 4'b1010) into the rsp_* registers, set rsp_valid=1, go to RESP.
  - RESP: rsp_* stable while rsp_valid && !rsp_ready. On the handshake edge:
    - If FIFO non-empty: pop the next command into alu_*, reload the counter, go to WAIT, rsp_valid=0.
    - Else: go to IDLE, rsp_valid=0.
- Latency: command pushed into an empty FIFO in IDLE at edge t -> popped at edge t+1 -> rsp_valid high after edge t+1+SETTLE.
- Throughput with rsp_ready held 1: one response every SETTLE+1 cycles.
- alu_a/alu_b/alu_sel change only on pop edges and hold their last values in IDLE/RESP (no toggling while waiting).
- Simultaneous push and pop on one edge: both take effect, cmd_count unchanged. A push is never accepted when full, even if a pop occurs that edge.
- Pointer wrap: read/write pointers wrap modulo DEPTH; full/empty derived from the count, not pointer equality.
- Illegal opcode: still driven to the ALU; captured F/V/Z passed through unchanged; rsp_illegal=1.
- Reset asserted mid-WAIT or RESP: immediate return to reset values. First command after release behaves as from IDLE.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum: ADD=0000, SUB=0001, TWOS=0010, OR=0011, AND=0100, XOR=0101, NOT=0110, SLL=0111, SRL=1000, ASR=1001, ASL=1010.
  - ALU_OP_MAX=4'b1010.
  - alu_cmd_t packed struct {a[2:0], b[2:0], sel[3:0]}.
  - seq_state_e {IDLE, WAIT, RESP}.
- One sub-module alu_cmd_fifo (DEPTH x alu_cmd_t, push/pop/full/empty/count); the FSM stays in the top.

Test Plan (3-bit ALU connected, SETTLE=1, DEPTH=4):
- Single ADD A=3 B=5 pushed at edge t -> rsp_valid high after edge t+2, rsp_f=5'b01000, rsp_v=1, rsp_z=0, rsp_sel=0000, rsp_illegal=0.
- SUB A=2 B=2 -> rsp_f=0, rsp_z=1, rsp_v=0. Then XOR A=5 B=3 -> rsp_f=5'b00110, rsp_z=0. Responses arrive in order.
- rsp_ready=0, cmd_valid held with 6 commands -> 5 accepted (1 in flight, 4 in FIFO), cmd_ready=0, cmd_count=4, rsp_* stable. Then release rsp_ready=1 -> all 5 responses drain in order, one every 2 cycles; cmd_count reaches 0 and busy drops.
- cmd_sel=4'b1111 A=7 B=7 -> rsp_illegal=1, rsp_f=0, rsp_z=1, rsp_v=0.
- Full FIFO with rsp_ready=1 and continuous cmd_valid -> push and pop on the same edge keep cmd_count constant; pointers wrap past DEPTH without losing or duplicating entries (scoreboard check of 20 random commands).
- Assert rst for 1 cycle during WAIT with 3 commands queued -> rsp_valid=0, cmd_count=0, busy=0, alu_*=0 immediately. A new ADD 1+1 afterwards -> rsp_f=5'b00010 with standard latency.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode, command and sequencer-state types shared by the ALU command sequencer.
package alu_pkg;
  typedef enum logic [3:0] {
    ADD  = 4'b0000,
    SUB  = 4'b0001,
    TWOS = 4'b0010,
    OR   = 4'b0011,
    AND  = 4'b0100,
    XOR  = 4'b0101,
    NOT  = 4'b0110,
    SLL  = 4'b0111,
    SRL  = 4'b1000,
    ASR  = 4'b1001,
    ASL  = 4'b1010
  } alu_op_e;
  localparam logic [3:0] ALU_OP_MAX = 4'b1010;
  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [3:0] sel;
  } alu_cmd_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} seq_state_e;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: DEPTH-entry command FIFO; full/empty derive from the occupancy count, pointers wrap naturally.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  alu_cmd_t      data_i,
  output alu_cmd_t      data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  alu_cmd_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign full_o = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign data_o = mem_q[rd_q];
  always_comb begin
    do_push = push_i && !full_o;
    do_pop = pop_i && !empty_o;
    wr_d = do_push ? wr_q + AW'(1) : wr_q;
    rd_d = do_pop ? rd_q + AW'(1) : rd_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, drives them to the ALU one at a time,
// waits SETTLE cycles and returns the captured F/V/Z strictly in command order.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SETTLE = 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int TW = $clog2(SETTLE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_a,
  input  logic [2:0]    cmd_b,
  input  logic [3:0]    cmd_sel,
  output logic [2:0]    alu_a,
  output logic [2:0]    alu_b,
  output logic [3:0]    alu_sel,
  input  logic [4:0]    alu_f,
  input  logic          alu_v,
  input  logic          alu_z,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [4:0]    rsp_f,
  output logic          rsp_v,
  output logic          rsp_z,
  output logic [3:0]    rsp_sel,
  output logic          rsp_illegal,
  output logic          busy,
  output logic [CW-1:0] cmd_count
);
  typedef struct packed {
    logic [4:0] f;
    logic       v;
    logic       z;
    logic [3:0] sel;
    logic       illegal;
  } rsp_t;
  seq_state_e state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  alu_cmd_t alu_q, alu_d, head;
  rsp_t rsp_q, rsp_d;
  logic pop, full, empty;
  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (cmd_valid && cmd_ready),
    .pop_i  (pop),
    .data_i ({cmd_a, cmd_b, cmd_sel}),
    .data_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(cmd_count)
  );
  assign cmd_ready = !full && !rst;
  assign busy = state_q != IDLE || !empty;
  assign rsp_valid = state_q == RESP;
  assign {alu_a, alu_b, alu_sel} = alu_q;
  assign {rsp_f, rsp_v, rsp_z, rsp_sel, rsp_illegal} = rsp_q;
  always_comb begin
    state_d = state_q;
    tmr_d = tmr_q;
    alu_d = alu_q;
    rsp_d = rsp_q;
    pop = 1'b0;
    case (state_q)
      IDLE: pop = !empty;
      WAIT: begin
        tmr_d = tmr_q - TW'(1);
        if (tmr_q == TW'(1)) begin
          rsp_d = {alu_f, alu_v, alu_z, alu_q.sel, alu_q.sel > ALU_OP_MAX};
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready) begin
        pop = !empty;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // every pop, from IDLE or straight out of a handshake, starts a fresh settle window
    if (pop) begin
      alu_d = head;
      tmr_d = TW'(SETTLE);
      state_d = WAIT;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q <= '0;
      alu_q <= '0;
      rsp_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      alu_q <= alu_d;
      rsp_q <= rsp_d;
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: sequencer driving a behavioural 3-bit ALU, checked against a queue-based model.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;
  localparam int DEPTH = 4;
  localparam int SETTLE = 1;
  logic clk = 0;
  logic rst = 1;
  logic cmd_valid = 0;
  logic cmd_ready;
  logic [2:0] cmd_a = 0, cmd_b = 0;
  logic [3:0] cmd_sel = 0;
  logic [2:0] alu_a, alu_b;
  logic [3:0] alu_sel;
  logic [4:0] alu_f;
  logic alu_v, alu_z;
  logic rsp_valid;
  logic rsp_ready = 0;
  logic [4:0] rsp_f;
  logic rsp_v, rsp_z;
  logic [3:0] rsp_sel;
  logic rsp_illegal, busy;
  logic [2:0] cmd_count;
  alu_cmd_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_f(alu_f), .alu_v(alu_v), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f), .rsp_v(rsp_v), .rsp_z(rsp_z),
    .rsp_sel(rsp_sel), .rsp_illegal(rsp_illegal), .busy(busy), .cmd_count(cmd_count)
  );
  always #5 clk = ~clk;
  // behavioural 3-bit ALU: returns {f, v, z}
  function automatic logic [6:0] alu_ref(input logic [2:0] a, input logic [2:0] b, input logic [3:0] s);
    logic [4:0] f;
    logic v;
    f = '0;
    v = 1'b0;
    case (s)
      4'd0: begin f = {2'b0, a} + {2'b0, b}; v = f[3]; end
      4'd1: begin f = {2'b0, 3'(a - b)}; v = a < b; end
      4'd2: f = {2'b0, 3'(-a)};
      4'd3: f = {2'b0, a | b};
      4'd4: f = {2'b0, a & b};
      4'd5: f = {2'b0, a ^ b};
      4'd6: f = {2'b0, ~a};
      4'd7: f = {1'b0, a, 1'b0};
      4'd8: f = {3'b0, a[2:1]};
      4'd9: f = {2'b0, a[2], a[2:1]};
      4'd10: begin f = {2'b0, a[1:0], 1'b0}; v = a[2] ^ a[1]; end
      default: f = '0;
    endcase
    return {f, v, f == 5'd0};
  endfunction
  assign {alu_f, alu_v, alu_z} = alu_ref(alu_a, alu_b, alu_sel);
  alu_cmd_t pend[$];
  alu_cmd_t last;
  bit act, rsp_out;
  int tmr;
  int n_chk = 0, n_fail = 0, dut_hs = 0;
  function automatic alu_cmd_t mk(input logic [2:0] a, input logic [2:0] b, input logic [3:0] s);
    return '{a: a, b: b, sel: s};
  endfunction
  function automatic alu_cmd_t rnd_cmd();
    return mk(3'($urandom_range(7)), 3'($urandom_range(7)), 4'($urandom_range(15)));
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    pend.delete();
    act = 0;
    rsp_out = 0;
    tmr = 0;
    last = '0;
  endtask
  // one clock edge of the transaction model, evaluated from pre-edge state
  task automatic model_edge(input bit v, input alu_cmd_t c, input bit rdy, output bit acc);
    int occ;
    occ = pend.size() - int'(act);
    acc = v && occ < DEPTH && !rst;
    if (rst) return;
    if (rsp_out) begin
      if (rdy) begin
        void'(pend.pop_front());
        rsp_out = 0;
        act = 0;
      end
    end else if (act) begin
      tmr--;
      if (tmr == 0) rsp_out = 1;
    end
    if (!act && occ > 0) begin
      act = 1;
      tmr = SETTLE;
      last = pend[0];
    end
    if (acc) pend.push_back(c);
  endtask
  task automatic check_all();
    int occ;
    occ = pend.size() - int'(act);
    chk("cmd_ready", cmd_ready, !rst && occ < DEPTH);
    chk("cmd_count", cmd_count, occ);
    chk("busy", busy, pend.size() > 0);
    chk("rsp_valid", rsp_valid, rsp_out);
    chk("alu_in", {alu_a, alu_b, alu_sel}, last);
    if (rsp_out) begin
      chk("rsp_fvz", {rsp_f, rsp_v, rsp_z}, alu_ref(pend[0].a, pend[0].b, pend[0].sel));
      chk("rsp_sel", rsp_sel, pend[0].sel);
      chk("rsp_illegal", rsp_illegal, pend[0].sel > 4'd10);
    end
  endtask
  task automatic step(input bit v, input alu_cmd_t c, input bit rdy, output bit acc);
    cmd_valid = v;
    {cmd_a, cmd_b, cmd_sel} = c;
    rsp_ready = rdy;
    if (rsp_valid && rdy) dut_hs++;
    @(posedge clk);
    model_edge(v, c, rdy, acc);
    #1 check_all();
  endtask
  // push one command into an idle sequencer and check the exact response latency
  task automatic latency_cmd(input string tag, input alu_cmd_t c, input logic [6:0] fvz, input bit ill);
    bit acc;
    step(1, c, 0, acc);
    step(0, '0, 0, acc);
    chk({tag, "_lat1"}, rsp_valid, 0);
    step(0, '0, 0, acc);
    chk({tag, "_lat2"}, rsp_valid, 1);
    chk({tag, "_fvz"}, {rsp_f, rsp_v, rsp_z}, fvz);
    chk({tag, "_sel"}, rsp_sel, c.sel);
    chk({tag, "_ill"}, rsp_illegal, ill);
    step(0, '0, 1, acc);
  endtask
  task automatic expect_rsp(input string tag, input logic [6:0] fvz, input bit ill);
    bit acc;
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step(0, '0, 0, acc);
      n++;
    end
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_fvz"}, {rsp_f, rsp_v, rsp_z}, fvz);
    chk({tag, "_ill"}, rsp_illegal, ill);
    step(0, '0, 1, acc);
  endtask
  task automatic drain(input string tag, input int exp_rsp);
    bit acc;
    int h0, n;
    h0 = dut_hs;
    n = 0;
    while ((busy || rsp_valid) && n < 100) begin
      step(0, '0, 1, acc);
      n++;
    end
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsps"}, dut_hs - h0, exp_rsp);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    bit acc;
    int k, n, h0;
    alu_cmd_t c;
    alu_cmd_t cmds[6];
    model_reset();
    #12;
    check_all();
    chk("rst_rsp", {rsp_f, rsp_v, rsp_z, rsp_sel, rsp_illegal}, 0);
    rst = 0;
    latency_cmd("add", mk(3, 5, ADD), 7'b0100010, 0);
    step(1, mk(2, 2, SUB), 0, acc);
    step(1, mk(5, 3, XOR), 0, acc);
    expect_rsp("sub", 7'b0000001, 0);
    expect_rsp("xor", 7'b0011000, 0);
    drain("order", 0);
    for (int i = 0; i < 6; i++) cmds[i] = rnd_cmd();
    k = 0;
    for (int i = 0; i < 12; i++) begin
      step(k < 6, k < 6 ? cmds[k] : '0, 0, acc);
      if (acc) k++;
    end
    chk("bp_count", cmd_count, 4);
    chk("bp_ready", cmd_ready, 0);
    chk("bp_valid", rsp_valid, 1);
    drain("bp", 5);
    latency_cmd("ill", mk(7, 7, 4'hF), 7'b0000001, 1);
    k = 0;
    n = 0;
    h0 = dut_hs;
    c = rnd_cmd();
    while (k < 20 && n < 200) begin
      step(1, c, n >= 8, acc);
      if (acc) begin
        k++;
        c = rnd_cmd();
      end
      n++;
    end
    chk("rnd_accepted", k, 20);
    while ((busy || rsp_valid) && n < 400) begin
      step(0, '0, 1, acc);
      n++;
    end
    chk("rnd_busy", busy, 0);
    chk("rnd_rsps", dut_hs - h0, 20);
    n = 0;
    while (!(act && !rsp_out && pend.size() - int'(act) >= 3) && n < 30) begin
      step(1, rnd_cmd(), 1, acc);
      n++;
    end
    chk("rst_in_wait", dut.state_q == WAIT, 1);
    cmd_valid = 0;
    #3 rst = 1;
    model_reset();
    #1 check_all();
    chk("rst_mid_rsp", {rsp_f, rsp_v, rsp_z, rsp_sel, rsp_illegal}, 0);
    @(posedge clk);
    #1 check_all();
    rst = 0;
    latency_cmd("post_rst", mk(1, 1, ADD), 7'b0001000, 0);
    drain("final", 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
